// File: rtl/cycle_count_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cycle_count_reader_pkg
// Brief    : Shared constants and state encoding for the stopwatch peripheral.
// Revision : 1.0
// ============================================================================
package cycle_count_reader_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 2;

    // Word-addressed register map
    localparam int REG_CTRL       = 0;
    localparam int REG_ELAPSED    = 1;
    localparam int REG_COMPARE    = 2;
    localparam int REG_START_SNAP = 3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_STOP_BIT  = 1;
    localparam int CTRL_CLEAR_BIT = 2;

    localparam int STATUS_RUN_BIT   = 0;
    localparam int STATUS_STOP_BIT  = 1;
    localparam int STATUS_ALARM_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

endpackage : cycle_count_reader_pkg
`default_nettype wire

// File: rtl/cycle_count_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : cycle_count_reader_if
// Brief    : Data-memory bus slave port of the stopwatch peripheral.
// Revision : 1.0
// ============================================================================
interface cycle_count_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              Sel;
    logic [ADDR_W-1:0] Addr;
    logic              MemWrite;
    logic              MemRead;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              ReadValid;

    modport master (
        output Sel, Addr, MemWrite, MemRead, WriteData,
        input  ReadData, ReadValid
    );

    modport slave (
        input  Sel, Addr, MemWrite, MemRead, WriteData,
        output ReadData, ReadValid
    );
endinterface : cycle_count_reader_if
`default_nettype wire

// File: rtl/cycle_count_reader_elapsed_calc.sv
`default_nettype none
// ============================================================================
// Module   : cycle_count_reader_elapsed_calc
// Brief    : Combinational elapsed-cycle computation and alarm threshold hit.
// Revision : 1.0
// ============================================================================
module cycle_count_reader_elapsed_calc
    import cycle_count_reader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  state_e            state_i,
    input  logic [DATA_W-1:0] cycle_count_i,
    input  logic [DATA_W-1:0] start_snap_i,
    input  logic [DATA_W-1:0] stop_snap_i,
    input  logic [DATA_W-1:0] compare_i,
    output logic [DATA_W-1:0] elapsed_o,
    output logic              hit_o
);

    // Modular subtraction makes a counter wrap inside the interval invisible
    always_comb begin
        elapsed_o = '0;
        unique case (state_i)
            ST_RUNNING: elapsed_o = cycle_count_i - start_snap_i;
            ST_STOPPED: elapsed_o = stop_snap_i - start_snap_i;
            default:    elapsed_o = '0;
        endcase
    end

    assign hit_o = (state_i == ST_RUNNING) && (compare_i != '0) && (elapsed_o >= compare_i);

endmodule : cycle_count_reader_elapsed_calc
`default_nettype wire

// File: rtl/cycle_count_reader.sv
`default_nettype none
// ============================================================================
// Module   : cycle_count_reader
// Brief    : Memory-mapped stopwatch over the free-running cycle count.
// Revision : 1.0
// ============================================================================
module cycle_count_reader
    import cycle_count_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [DATA_W-1:0]    CycleCount,
    cycle_count_reader_if.slave  bus,
    output logic                 Alarm
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] start_snap_q, start_snap_d;
    logic [DATA_W-1:0] stop_snap_q, stop_snap_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              alarm_q, alarm_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;

    logic [DATA_W-1:0] w_elapsed;
    logic              w_hit;
    logic [DATA_W-1:0] w_status;
    logic              w_wr;
    logic              w_rd;
    logic              w_ctrl_wr;
    logic              w_cmp_wr;

    cycle_count_reader_elapsed_calc #(
        .DATA_W (DATA_W)
    ) u_elapsed_calc (
        .state_i       (state_q),
        .cycle_count_i (CycleCount),
        .start_snap_i  (start_snap_q),
        .stop_snap_i   (stop_snap_q),
        .compare_i     (compare_q),
        .elapsed_o     (w_elapsed),
        .hit_o         (w_hit)
    );

    assign w_wr      = bus.Sel && bus.MemWrite;
    assign w_rd      = bus.Sel && bus.MemRead;
    assign w_ctrl_wr = w_wr && (bus.Addr == ADDR_W'(REG_CTRL));
    assign w_cmp_wr  = w_wr && (bus.Addr == ADDR_W'(REG_COMPARE));

    always_comb begin
        w_status                   = '0;
        w_status[STATUS_RUN_BIT]   = (state_q == ST_RUNNING);
        w_status[STATUS_STOP_BIT]  = (state_q == ST_STOPPED);
        w_status[STATUS_ALARM_BIT] = alarm_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            start_snap_q <= '0;
            stop_snap_q  <= '0;
            compare_q    <= '0;
            alarm_q      <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_snap_q <= start_snap_d;
            stop_snap_q  <= stop_snap_d;
            compare_q    <= compare_d;
            alarm_q      <= alarm_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        start_snap_d = start_snap_q;
        stop_snap_d  = stop_snap_q;
        compare_d    = compare_q;
        alarm_d      = alarm_q | w_hit;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;

        // Command priority within one write: CLEAR, then START, then STOP
        if (w_ctrl_wr) begin
            if (bus.WriteData[CTRL_CLEAR_BIT]) begin
                state_d      = ST_IDLE;
                start_snap_d = '0;
                stop_snap_d  = '0;
                alarm_d      = 1'b0;
            end else if (bus.WriteData[CTRL_START_BIT]) begin
                state_d      = ST_RUNNING;
                start_snap_d = CycleCount;
                alarm_d      = 1'b0;
            end else if (bus.WriteData[CTRL_STOP_BIT] && (state_q == ST_RUNNING)) begin
                state_d     = ST_STOPPED;
                stop_snap_d = CycleCount;
            end
        end

        if (w_cmp_wr) begin
            compare_d = bus.WriteData;
        end

        // Read mux uses current-cycle values, so a same-cycle write is not visible
        if (w_rd) begin
            read_valid_d = 1'b1;
            case (bus.Addr)
                ADDR_W'(REG_CTRL):       read_data_d = w_status;
                ADDR_W'(REG_ELAPSED):    read_data_d = w_elapsed;
                ADDR_W'(REG_COMPARE):    read_data_d = compare_q;
                ADDR_W'(REG_START_SNAP): read_data_d = start_snap_q;
                default:                 read_data_d = '0;
            endcase
        end
    end

    assign bus.ReadData  = read_data_q;
    assign bus.ReadValid = read_valid_q;
    assign Alarm         = alarm_q;

endmodule : cycle_count_reader
`default_nettype wire

// File: tb/tb_cycle_count_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cycle_count_reader
// Brief    : Self-checking bench: directed scenarios plus randomized traffic.
// Revision : 1.0
// ============================================================================
module tb_cycle_count_reader;

    logic        CLK;
    logic        Reset;
    logic [31:0] CycleCount;
    logic        Alarm;

    cycle_count_reader_if #(.DATA_W(32), .ADDR_W(2)) bus ();

    cycle_count_reader #(.DATA_W(32), .ADDR_W(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .CycleCount (CycleCount),
        .bus        (bus),
        .Alarm      (Alarm)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 = no interval, 1 = interval open, 2 = interval frozen
    int          m_mode  = 0;
    logic [31:0] m_start = 0;
    logic [31:0] m_stop  = 0;
    logic [31:0] m_cmp   = 0;
    logic        m_alarm = 0;
    logic        e_valid = 0;
    logic [31:0] e_rdata = 0;

    function automatic logic [31:0] m_elapsed(input logic [31:0] cc);
        if (m_mode == 1) return cc - m_start;
        if (m_mode == 2) return m_stop - m_start;
        return 32'd0;
    endfunction

    always @(posedge CLK) begin
        logic [31:0] el;
        logic        hit;
        el = m_elapsed(CycleCount);
        if (Reset) begin
            m_mode = 0; m_start = 0; m_stop = 0; m_cmp = 0; m_alarm = 0;
            e_valid = 0; e_rdata = 0;
        end else begin
            e_valid = bus.Sel && bus.MemRead;
            if (e_valid) begin
                case (bus.Addr)
                    2'd0:    e_rdata = {29'd0, m_alarm, m_mode == 2, m_mode == 1};
                    2'd1:    e_rdata = el;
                    2'd2:    e_rdata = m_cmp;
                    default: e_rdata = m_start;
                endcase
            end
            hit = (m_mode == 1) && (m_cmp != 0) && (el >= m_cmp);
            if (hit) m_alarm = 1;
            if (bus.Sel && bus.MemWrite && bus.Addr == 2'd0) begin
                if (bus.WriteData[2]) begin
                    m_mode = 0; m_start = 0; m_stop = 0; m_alarm = 0;
                end else if (bus.WriteData[0]) begin
                    m_mode = 1; m_start = CycleCount; m_alarm = 0;
                end else if (bus.WriteData[1] && m_mode == 1) begin
                    m_mode = 2; m_stop = CycleCount;
                end
            end
            if (bus.Sel && bus.MemWrite && bus.Addr == 2'd2) m_cmp = bus.WriteData;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("ReadValid", 32'(bus.ReadValid), 32'(e_valid));
            chk("ReadData", bus.ReadData, e_rdata);
            chk("Alarm", 32'(Alarm), 32'(m_alarm));
        end
    end

    task automatic next_cycle();
        @(negedge CLK);
        CycleCount    = CycleCount + 32'd1;
        Reset         = 1'b0;
        bus.Sel       = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
    endtask

    task automatic drive_wr(input logic [1:0] a, input logic [31:0] d);
        bus.Sel = 1'b1; bus.MemWrite = 1'b1; bus.Addr = a; bus.WriteData = d;
    endtask

    task automatic drive_rd(input logic [1:0] a);
        bus.Sel = 1'b1; bus.MemRead = 1'b1; bus.Addr = a;
    endtask

    task automatic wr_at(input logic [31:0] cc, input logic [1:0] a, input logic [31:0] d);
        next_cycle();
        CycleCount = cc;
        drive_wr(a, d);
    endtask

    task automatic rd_expect(input string name, input logic [1:0] a, input logic [31:0] exp);
        next_cycle();
        drive_rd(a);
        next_cycle();
        chk({name, " valid"}, 32'(bus.ReadValid), 32'd1);
        chk(name, bus.ReadData, exp);
    endtask

    initial begin
        Reset = 1'b1; CycleCount = 32'd0;
        bus.Sel = 1'b0; bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
        bus.Addr = 2'd0; bus.WriteData = 32'd0;
        @(posedge CLK);
        chk_en = 1'b1;
        next_cycle(); Reset = 1'b1;
        next_cycle();

        // Reset state
        chk("reset alarm", 32'(Alarm), 32'd0);
        for (int a = 0; a < 4; a++) rd_expect("reset read", 2'(a), 32'd0);

        // Start/stop interval
        wr_at(32'd100, 2'd0, 32'h1);
        repeat (10) next_cycle();
        wr_at(32'd150, 2'd0, 32'h2);
        rd_expect("elapsed stopped", 2'd1, 32'd50);
        next_cycle(); CycleCount = 32'h1234_5678;
        rd_expect("elapsed frozen", 2'd1, 32'd50);
        rd_expect("status stopped", 2'd0, 32'h2);

        // Wrap of the cycle count
        wr_at(32'hFFFF_FFF0, 2'd0, 32'h1);
        next_cycle(); CycleCount = 32'h0000_0010; drive_rd(2'd1);
        next_cycle();
        chk("wrap elapsed", bus.ReadData, 32'h20);
        rd_expect("status running", 2'd0, 32'h1);

        // Alarm threshold
        wr_at(32'd500, 2'd2, 32'd40);
        wr_at(32'd1000, 2'd0, 32'h1);
        for (int i = 0; i < 40; i++) next_cycle();
        chk("alarm before hit", 32'(Alarm), 32'd0);
        next_cycle();
        chk("alarm at hit", 32'(Alarm), 32'd1);
        wr_at(32'd1100, 2'd0, 32'h2);
        repeat (3) next_cycle();
        chk("alarm sticky after stop", 32'(Alarm), 32'd1);
        wr_at(32'd2000, 2'd0, 32'h1);
        next_cycle();
        chk("alarm cleared by start", 32'(Alarm), 32'd0);

        // Command priority
        wr_at(32'd2010, 2'd0, 32'h7);
        rd_expect("elapsed after clear", 2'd1, 32'd0);
        chk("alarm after clear", 32'(Alarm), 32'd0);
        wr_at(32'd5000, 2'd0, 32'h3);
        rd_expect("status start beats stop", 2'd0, 32'h1);
        rd_expect("start snap", 2'd3, 32'd5000);

        // Reset while running with a read pending
        next_cycle(); drive_rd(2'd0); Reset = 1'b1;
        next_cycle();
        chk("no valid after reset", 32'(bus.ReadValid), 32'd0);
        rd_expect("status after reset", 2'd0, 32'd0);
        rd_expect("compare after reset", 2'd2, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            next_cycle();
            if ($urandom_range(0, 15) == 0) CycleCount = $urandom;
            if ($urandom_range(0, 99) == 0) Reset = 1'b1;
            bus.Sel      = ($urandom_range(0, 3) != 0);
            bus.MemRead  = ($urandom_range(0, 2) == 0);
            bus.MemWrite = ($urandom_range(0, 3) == 0);
            bus.Addr     = 2'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            if (bus.Addr == 2'd2)      bus.WriteData = 32'($urandom_range(0, 30));
            else if (r < 4)            bus.WriteData = 32'h1;
            else if (r < 7)            bus.WriteData = 32'h2;
            else if (r == 7)           bus.WriteData = 32'h4;
            else                       bus.WriteData = $urandom;
        end
        repeat (3) next_cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_cycle_count_reader
`default_nettype wire
